// File: rtl/instr_encoder.sv
// Encodes abstract ALU/CSR requests into RV32I/M instruction words, buffered in an in-order FIFO.
// Optional INSTR_ENC_NOP_FILL_EN: an empty FIFO presents ADDI x0,x0,0 as a valid head.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_kind,
    input  logic [3:0]               in_op,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [19:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_SYS = 7'b1110011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          err_reg;

    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          op_legal;
    logic          op_sub_or_mul;
    logic          op_shift;
    logic [11:0]   imm12;
    logic          req_legal;
    logic [31:0]   instr_next;

    logic          accept, push, pop, empty;
    logic [DEPTH-1:0] wr_en;

    // ALU op table shared by R- and I-type; I-type additionally excludes SUB and MUL*.
    always_comb begin
        f3            = 3'b000;
        f7            = 7'b0000000;
        op_legal      = 1'b1;
        op_sub_or_mul = 1'b0;
        op_shift      = 1'b0;
        case (in_op)
            4'b0000: f3 = 3'b111;
            4'b0001: f3 = 3'b110;
            4'b0010: f3 = 3'b100;
            4'b0011: f3 = 3'b000;
            4'b0100: begin f3 = 3'b000; f7 = 7'b0100000; op_sub_or_mul = 1'b1; end
            4'b0101: begin f3 = 3'b000; f7 = 7'b0000001; op_sub_or_mul = 1'b1; end
            4'b0110: begin f3 = 3'b001; f7 = 7'b0000001; op_sub_or_mul = 1'b1; end
            4'b0111: begin f3 = 3'b011; f7 = 7'b0000001; op_sub_or_mul = 1'b1; end
            4'b1000: begin f3 = 3'b001; op_shift = 1'b1; end
            4'b1001: begin f3 = 3'b101; op_shift = 1'b1; end
            4'b1010: begin f3 = 3'b101; f7 = 7'b0100000; op_shift = 1'b1; end
            4'b1100: f3 = 3'b010;
            4'b1101: f3 = 3'b011;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        imm12      = in_imm[11:0];
        req_legal  = 1'b1;
        instr_next = 32'h0;
        // Shift immediates carry f7 in their top bits; only the shamt comes from the request.
        if (op_shift)
            imm12[11:5] = f7;
        case (in_kind)
            2'd0: begin
                req_legal  = op_legal;
                instr_next = {f7, in_rs2, in_rs1, f3, in_rd, OPC_R};
            end
            2'd1: begin
                req_legal  = op_legal && !op_sub_or_mul;
                instr_next = {imm12, in_rs1, f3, in_rd, OPC_I};
            end
            2'd2: instr_next = {in_imm, in_rd, OPC_LUI};
            default: instr_next = {12'hF02, in_rs1, 3'b001, in_rd, OPC_SYS};
        endcase
    end

    assign empty    = (count_reg == '0);
    assign in_ready = (count_reg < FULL_COUNT);
    assign accept   = in_valid && in_ready;
    assign push     = accept && req_legal;
    assign pop      = out_ready && !empty;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage is not reset; stale contents are never visible because the output is gated by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i])
                mem_reg[i] <= instr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            if (accept && !req_legal)
                err_reg <= 1'b1;
        end
    end

`ifdef INSTR_ENC_NOP_FILL_EN
    assign out_valid = 1'b1;
    assign out_instr = empty ? NOP_INSTR : mem_reg[rd_ptr_reg];
`else
    assign out_valid = !empty;
    assign out_instr = empty ? 32'h0 : mem_reg[rd_ptr_reg];
`endif

    assign count = count_reg;
    assign err   = err_reg;

endmodule
